// File: rtl/gy26_angle_parser.sv
// GY-26 compass poller: issues a periodic read command and decodes the
// 8-byte ASCII heading frame (0D 0A D2 D1 D0 '.' DT CS) into tenths of a degree.
module gy26_angle_parser #(
    parameter int POLL_CYCLES    = 2_500_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        rxdone,
    input  logic [7:0]  rxdata,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic [11:0] angle,
    output logic        angle_valid,
    output logic        has_angle,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] POLL_TC = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_TC  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_HDR0, S_HDR1, S_DIG2, S_DIG1, S_DIG0, S_DOT, S_TENTH, S_SUM
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pcnt_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    cs_q;
    logic [13:0]   val_q;
    logic [11:0]   angle_q;
    logic          tx_en_q, angle_valid_q, has_angle_q, frame_err_q, timeout_err_q;

    logic          is_digit, byte_ok, timeout_hit, rx_state, digit_state;
    logic [7:0]    dig, cs_d;
    logic [13:0]   val_d;

    // Byte classification, running checksum/value candidates and timeout detect
    always_comb begin
        is_digit    = (rxdata >= 8'h30) && (rxdata <= 8'h39);
        dig         = rxdata - 8'h30;
        val_d       = (val_q * 14'd10) + {6'd0, dig};
        cs_d        = cs_q + rxdata;
        rx_state    = (state_q != S_IDLE) && (state_q != S_REQ);
        digit_state = (state_q == S_DIG2) || (state_q == S_DIG1) ||
                      (state_q == S_DIG0) || (state_q == S_TENTH);
        timeout_hit = rx_state && (tcnt_q == TMO_TC);
        byte_ok     = 1'b0;
        case (state_q)
            S_HDR0:  byte_ok = (rxdata == 8'h0D);
            S_HDR1:  byte_ok = (rxdata == 8'h0A);
            S_DIG2, S_DIG1, S_DIG0, S_TENTH: byte_ok = is_digit;
            S_DOT:   byte_ok = (rxdata == 8'h2E);
            S_SUM:   byte_ok = (rxdata == cs_q) && (val_q <= 14'd3599);
            default: byte_ok = 1'b0;
        endcase
    end

    // Poll/receive FSM with registered outputs; reset overrides everything
    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pcnt_q        <= '0;
            tcnt_q        <= '0;
            cs_q          <= '0;
            val_q         <= '0;
            angle_q       <= '0;
            tx_en_q       <= 1'b0;
            angle_valid_q <= 1'b0;
            has_angle_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_en_q       <= 1'b0;
            angle_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pcnt_q == POLL_TC) begin
                        pcnt_q  <= '0;
                        state_q <= S_REQ;
                        tx_en_q <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                S_REQ: begin
                    // The REQ cycle itself is cycle 0 of the response window.
                    tcnt_q  <= TW'(1);
                    cs_q    <= '0;
                    val_q   <= '0;
                    state_q <= S_HDR0;
                end
                default: begin
                    if (timeout_hit) begin
                        // Timeout beats a same-cycle byte, which is dropped.
                        timeout_err_q <= 1'b1;
                        tcnt_q        <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (rxdone) begin
                            if (state_q == S_SUM) begin
                                if (byte_ok) begin
                                    angle_q       <= val_q[11:0];
                                    angle_valid_q <= 1'b1;
                                    has_angle_q   <= 1'b1;
                                end else begin
                                    frame_err_q <= 1'b1;
                                end
                                tcnt_q  <= '0;
                                state_q <= S_IDLE;
                            end else if (byte_ok) begin
                                cs_q    <= cs_d;
                                if (digit_state) val_q <= val_d;
                                state_q <= state_t'(state_q + 4'd1);
                            end else begin
                                // Resync inside the same window; a stray 0D may start a new frame.
                                frame_err_q <= 1'b1;
                                val_q       <= '0;
                                if (rxdata == 8'h0D) begin
                                    cs_q    <= 8'h0D;
                                    state_q <= S_HDR1;
                                end else begin
                                    cs_q    <= '0;
                                    state_q <= S_HDR0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign tx_data     = 8'h31;
    assign tx_en       = tx_en_q;
    assign angle       = angle_q;
    assign angle_valid = angle_valid_q;
    assign has_angle   = has_angle_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/gy26_angle_parser.md
# gy26_angle_parser

Polls the GY-26 electronic compass and decodes its 8-byte ASCII heading frame into a binary angle in tenths of a degree. It sits directly downstream of `uart_rx_angle`, consuming its `rxdone`/`rxdata` byte strobe, and drives a one-byte read command toward the compass UART transmitter. Its `angle` output feeds the heading logic in `action`.

## Interface
- `POLL_CYCLES`, default 2_500_000: number of IDLE cycles between read requests (50 ms at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of cycles from a request to checksum-byte receipt.
- `clk0`  in  1  system clock, 50 MHz; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rxdone`  in  1  one-cycle strobe from `uart_rx_angle`: byte valid.
- `rxdata`  in  8  received byte; sampled only when `rxdone`=1.
- `tx_data`  out  8  command byte; constant 0x31 (read angle).
- `tx_en`  out  1  one-cycle send strobe to the compass UART transmitter.
- `angle`  out  12  last good heading, 0..3599, in tenths of a degree.
- `angle_valid`  out  1  one-cycle pulse when `angle` updates.
- `has_angle`  out  1  sticky; set by the first good frame, cleared only by reset.
- `frame_err`  out  1  one-cycle pulse on a malformed or rejected frame.
- `timeout_err`  out  1  one-cycle pulse when a request times out.

## Operation
- Frame format: 0x0D, 0x0A, D2, D1, D0, 0x2E, DT, CS.
  - D2, D1, D0 and DT are ASCII '0'..'9' (0x30..0x39).
  - CS = (sum of the first 7 bytes) mod 256.
- States: IDLE, REQ, HDR0, HDR1, DIG2, DIG1, DIG0, DOT, TENTH, SUM.
- IDLE:
  - The poll counter counts 0..POLL_CYCLES-1; at terminal count the state goes to REQ.
  - The counter clears whenever IDLE is left.
- REQ: lasts one cycle. Asserts `tx_en`, clears the timeout counter and checksum accumulator, then goes to HDR0.
- Receive states (HDR0..SUM):
  - Advance only on `rxdone`.
  - Each accepted byte is added to an 8-bit wrapping checksum accumulator. The CS byte is compared, not added.
- Digit states compute value = value*10 + (byte-0x30) into a 14-bit accumulator (max 9999).
- Success at SUM requires all of the following:
  - the checksum matches;
  - value ≤ 3599.
  - On success: latch `angle` = value[11:0], pulse `angle_valid`, set `has_angle`, go to IDLE.
- Any mismatch causes a `frame_err` pulse. Mismatches are: wrong header byte, non-digit, wrong dot, bad checksum, or range > 3599.
  - After a mismatch in any state other than SUM, the block resynchronises in the same request window. If the offending byte is 0x0D, go to HDR1 with the checksum seeded to 0x0D; otherwise go to HDR0 with the checksum cleared.
  - A mismatch at SUM goes to IDLE.
- Timeout:
  - The counter runs in all receive states.
  - Reaching TIMEOUT_CYCLES-1 pulses `timeout_err` and goes to IDLE; `angle` is unchanged.
  - If `rxdone` and timeout occur in the same cycle, the timeout wins and the byte is discarded.
- Bytes arriving in IDLE or REQ are discarded silently.
- `angle` changes only on success. Errors never alter `angle` or `has_angle`.

## Timing
- Reset values:
  - state IDLE; all counters 0;
  - `angle`=0; `angle_valid`=0; `has_angle`=0;
  - `frame_err`=0; `timeout_err`=0; `tx_en`=0;
  - `tx_data`=0x31, which is constant at all times.
- Reset is synchronous and takes priority over every event, including mid-frame. The cycle after reset deasserts, the block is in IDLE with the poll counter at 0.
- First `tx_en` is high exactly POLL_CYCLES cycles after the first non-reset cycle, and lasts 1 cycle.
- Each byte is consumed in the cycle its `rxdone` is high. Back-to-back `rxdone` on consecutive cycles must be handled.
- `angle`, `angle_valid` and `has_angle` update on the clock edge following the CS-byte `rxdone`, so they are visible one cycle later.
- `frame_err` and `timeout_err` are registered and appear 1 cycle after the causing event.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Good frame: after `tx_en`, send 0D 0A 31 32 33 2E 34 0F. Required: `angle`=1234 with one `angle_valid` pulse 1 cycle after the last `rxdone`, and `has_angle`=1.
- Bad checksum: same frame but CS=0x10. Required: one `frame_err` pulse, `angle` holds its prior value, no `angle_valid`, return to IDLE.
- Range reject: send 0D 0A 33 36 35 2E 30 13 (365.0). Required: `frame_err`; `angle` unchanged.
- Resync: after `tx_en`, send 0D 0D 0A 30 30 39 2E 35 and then the correct CS. Required: one `frame_err` on the second 0D, followed by `angle`=95.
- Timeout: issue a request and send no bytes. Required: `timeout_err` pulses TIMEOUT_CYCLES cycles after `tx_en`; the next `tx_en` follows POLL_CYCLES cycles later.
- Reset mid-frame: assert `rst` after the D1 byte, then release it. Required: all outputs return to their reset values, no `angle_valid` or error pulse, and `tx_en` recurs after POLL_CYCLES.
